// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: upstream sequencer for one MAC_pipeline lane.
// Pops paired A/B operands from two streams, issues exactly k_len pairs to the
// pipeline with the seed C_in held steady, then waits for store_valid and
// returns the captured result together with a sticky error flag.
// Optional build macro: DRAIN_TIMEOUT_EN (bounds the wait for store_valid to
// DRAIN_MAX cycles; on expiry the result is 0 with result_err set).
module mac_operand_feeder #(
  parameter int DATA_W    = 64,
  parameter int K_W       = 16,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [DATA_W-1:0] c_init,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              valid_in,
  output logic [DATA_W-1:0] TA_in,
  output logic [DATA_W-1:0] TB_in,
  output logic [DATA_W-1:0] C_in,
  input  logic [DATA_W-1:0] res_out,
  input  logic              store_valid,
  input  logic              error_flag,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              result_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [K_W-1:0]    k_len_q;
  logic [K_W-1:0]    issue_cnt_q;
  logic [K_W-1:0]    issue_cnt_d;
  logic              valid_in_q;
  logic [DATA_W-1:0] ta_q;
  logic [DATA_W-1:0] tb_q;
  logic [DATA_W-1:0] c_in_q;
  logic [DATA_W-1:0] result_q;
  logic              result_valid_q;
  logic              result_err_q;
  logic              pop;

`ifdef DRAIN_TIMEOUT_EN
  localparam int DrainW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_MAX - 1);
  logic [DrainW-1:0] drain_cnt_q;
`endif

  // Both streams pop together, and only while issuing; a lone valid never pops.
  assign pop         = (state_q == ISSUE) && a_valid && b_valid;
  assign a_ready     = pop;
  assign b_ready     = pop;
  // The counter never exceeds k_len-1 before incrementing, so it cannot wrap.
  assign issue_cnt_d = issue_cnt_q + K_W'(1);

  assign busy         = (state_q != IDLE);
  assign valid_in     = valid_in_q;
  assign TA_in        = ta_q;
  assign TB_in        = tb_q;
  assign C_in         = c_in_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_err   = result_err_q;

  // Sequencer FSM with all outputs registered; result_valid defaults low so it pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      k_len_q        <= '0;
      issue_cnt_q    <= '0;
      valid_in_q     <= 1'b0;
      ta_q           <= '0;
      tb_q           <= '0;
      c_in_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_err_q   <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
      drain_cnt_q    <= '0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          valid_in_q <= 1'b0;
          ta_q       <= '0;
          tb_q       <= '0;
          if (start) begin
            k_len_q      <= k_len;
            c_in_q       <= c_init;
            issue_cnt_q  <= '0;
            result_err_q <= 1'b0;
            if (k_len == '0) begin
              result_q       <= c_init;
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end else begin
              state_q <= ISSUE;
            end
          end
        end

        ISSUE: begin
          result_err_q <= result_err_q | error_flag;
          if (pop) begin
            ta_q        <= a_data;
            tb_q        <= b_data;
            valid_in_q  <= 1'b1;
            issue_cnt_q <= issue_cnt_d;
            if (issue_cnt_d == k_len_q) begin
              state_q <= DRAIN;
            end
          end else begin
            ta_q       <= '0;
            tb_q       <= '0;
            valid_in_q <= 1'b0;
          end
        end

        DRAIN: begin
          valid_in_q   <= 1'b0;
          ta_q         <= '0;
          tb_q         <= '0;
          result_err_q <= result_err_q | error_flag;
          if (store_valid) begin
            result_q       <= res_out;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
`ifdef DRAIN_TIMEOUT_EN
            drain_cnt_q    <= '0;
          end else if (drain_cnt_q == DrainLast) begin
            result_q       <= '0;
            result_err_q   <= 1'b1;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
            drain_cnt_q    <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q + DrainW'(1);
`endif
          end
        end

        DONE: begin
          valid_in_q <= 1'b0;
          state_q    <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
Upstream sequencer for MAC_pipeline. It pops paired A-row / B-column double-precision elements from two operand streams, drives TA_in/TB_in/valid_in/C_in for one k_len-long dot product, then waits for the pipeline's store_valid and returns res_out with a sticky error flag. It sits between the operand buffers and MAC_pipeline, one instance per MAC lane.

Parameters:
DATA_W, 64, operand/result width (IEEE-754 double)
K_W, 16, width of the dot-product length counter
DRAIN_MAX, 64, cycle limit in DRAIN (used only with DRAIN_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins an operation; honoured only in IDLE
k_len  in  K_W  number of A/B pairs; sampled on start
c_init  in  DATA_W  accumulator seed; sampled on start
a_data  in  DATA_W  A operand stream data
a_valid  in  1  A data available
a_ready  out  1  A pop
b_data  in  DATA_W  B operand stream data
b_valid  in  1  B data available
b_ready  out  1  B pop
valid_in  out  1  to MAC_pipeline: operand pair valid
TA_in  out  DATA_W  to MAC_pipeline: A operand
TB_in  out  DATA_W  to MAC_pipeline: B operand
C_in  out  DATA_W  to MAC_pipeline: seed value, held for the whole operation
res_out  in  DATA_W  from MAC_pipeline: result
store_valid  in  1  from MAC_pipeline: result valid
error_flag  in  1  from MAC_pipeline: arithmetic error
busy  out  1  high outside IDLE
result  out  DATA_W  captured result
result_valid  out  1  one-cycle pulse
result_err  out  1  sticky OR of error_flag over the operation; valid with result_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE. valid_in, a_ready, b_ready, busy, result_valid, result_err = 0. TA_in, TB_in, C_in, result = 0. Issue counter = 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches k_len and c_init. C_in <= c_init.
  - If k_len=0, go to DONE with result <= c_init and no issue.
  - Otherwise go to ISSUE.
- ISSUE:
  - a_ready = b_ready = a_valid & b_valid (combinational). Both streams pop in the same cycle or neither pops.
  - On a pop: TA_in <= a_data, TB_in <= b_data, valid_in <= 1 next cycle (1-cycle latency), counter increments.
  - No pop: valid_in <= 0 and TA_in/TB_in <= 0 (bubble). Bubbles are legal and unbounded.
  - When the counter reaches k_len on a pop, go to DRAIN. Exactly k_len pairs are issued.
- DRAIN:
  - valid_in = 0, a_ready = b_ready = 0.
  - On the first store_valid=1, result <= res_out and go to DONE.
  - A store_valid in the same cycle as the final issue is not a valid capture and is ignored.
- DONE: result_valid=1 for one cycle, then IDLE. busy drops in that same IDLE cycle.
- result_err:
  - Cleared on accepted start.
  - OR-ed with error_flag every cycle in ISSUE and DRAIN, including the store_valid cycle.
- Ignored inputs:
  - start while busy is ignored; no state change.
  - store_valid in IDLE or ISSUE is ignored.
- C_in holds its value until the next accepted start.
- Counter arithmetic: unsigned K_W bits; k_len max is 2^K_W-1 with no wrap.
- Reset mid-operation aborts immediately. Unpopped stream data stays in the external buffers.

Optional Feature:
Macro DRAIN_TIMEOUT_EN.
- Defined: a DRAIN cycle counter runs. If DRAIN_MAX cycles pass without store_valid, the block goes to DONE with result=0 and result_err=1. The counter clears on leaving DRAIN.
- Undefined: DRAIN waits indefinitely, and the counter logic and DRAIN_MAX are unused.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release -> IDLE, busy=0.
- Basic op: k_len=3, c_init=0x3FF0000000000000, A={0x4000000000000000 x3}, B={0x3FF0000000000000 x3} with both streams always valid -> exactly 3 consecutive valid_in pulses starting 1 cycle after the pops, C_in=0x3FF0000000000000. store_valid with res_out=0x401C000000000000 -> result matches, result_valid pulses once, result_err=0.
- Backpressure: a_valid toggles every cycle, b_valid always 1 -> a_ready=b_ready only when both valid, bubbles show TA_in=TB_in=0, total issued pairs = k_len = 4.
- k_len=0 with c_init=0x4025000000000000 -> no valid_in, a_ready/b_ready never high, result=0x4025000000000000 two cycles after start.
- Error and ignored start: error_flag pulses mid-ISSUE, and start pulses while busy -> result_err=1 at result_valid, the second start has no effect, and the next op clears result_err.
- DRAIN_TIMEOUT_EN defined, DRAIN_MAX=8, store_valid withheld -> result_valid 8 cycles into DRAIN with result=0, result_err=1. Assert rst_n=0 mid-ISSUE -> immediate IDLE.
